// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the sensor-link I2C slave receive path: the receive
// controller state encoding, the frame width, the default slave address and
// the sub-phase encoding used while clocking an ACK/NACK bit.
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int BITS_PER_BYTE = 8;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h1E;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_CHK  = 4'd2,
    ACK_ADDR  = 4'd3,
    DATA      = 4'd4,
    DATA_LOAD = 4'd5,
    ACK_DATA  = 4'd6,
    NACK      = 4'd7,
    WAIT_STOP = 4'd8
  } rx_ctrl_state_t;

  // Progress through the 9th SCL clock: wait for the falling edge that opens
  // the acknowledge slot, then the rise that the master samples, then the
  // falling edge that closes the slot.
  typedef enum logic [1:0] {
    PH_WAIT_FALL = 2'd0,
    PH_WAIT_RISE = 2'd1,
    PH_WAIT_END  = 2'd2
  } ack_phase_t;

endpackage

// File: rtl/rx_ctrl_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// 4-bit frame bit counter. Counts enabled events and wraps back to zero on
// the BITS_PER_BYTE-th event, so it sits at zero at every byte boundary.
// Kept separate so a future transmit controller can reuse it.
//
// Ports:
//   i_clk    system clock
//   i_n_rst  synchronous active-low reset
//   i_clr    synchronous clear (wins over i_en)
//   i_en     count one event this cycle
//   o_count  current count, 0 .. BITS_PER_BYTE-1
// -----------------------------------------------------------------------------
module bit_counter
  import i2c_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_count
);

  logic [3:0] r_count;
  logic       w_atTerminal;

  assign w_atTerminal = (r_count == 4'(BITS_PER_BYTE - 1));
  assign o_count      = r_count;

  // Terminal count wraps to zero so the next frame starts clean without
  // needing an explicit clear from the controller.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst || i_clr) begin
      r_count <= 4'd0;
    end else if (i_en) begin
      r_count <= w_atTerminal ? 4'd0 : r_count + 4'd1;
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// -----------------------------------------------------------------------------
// rx_ctrl
// I2C slave receive controller (write-only). Frames bytes from the receive
// shift register, checks the 7-bit address, acknowledges on SDA and hands
// data bytes to the filter side over a valid/ready handshake. Reads are not
// supported and are never acknowledged.
//
// Ports:
//   clk                 system clock
//   n_rst               synchronous active-low reset
//   start_found         pulse: START or repeated START on the bus
//   stop_found          pulse: STOP on the bus
//   rising_edge_found   pulse: SCL rising edge (also shifts the shift register)
//   falling_edge_found  pulse: SCL falling edge
//   rx_data[7:0]        shift register contents, MSB first
//   rx_enable           allows the shift register to shift
//   sda_drive_low       1 pulls SDA low (ACK), 0 releases it
//   byte_out[7:0]       received data byte
//   byte_valid          byte_out holds an unconsumed byte
//   byte_ready          consumer takes byte_out when byte_valid is high
//   addr_match          this slave was addressed in the current transfer
//   overrun             sticky: a data byte was dropped
//   clr_overrun         clears overrun
// -----------------------------------------------------------------------------
module rx_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  output logic       sda_drive_low,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       addr_match,
  output logic       overrun,
  input  logic       clr_overrun
);

  rx_ctrl_state_t r_state;
  rx_ctrl_state_t w_stateNext;
  ack_phase_t     r_phase;
  ack_phase_t     w_phaseNext;

  logic       r_sda;
  logic       w_sdaNext;
  logic       r_match;
  logic       w_matchNext;
  logic [7:0] r_byteOut;
  logic       r_valid;
  logic       r_overrun;

  logic       w_load;
  logic       w_setOverrun;
  logic       w_cntClr;
  logic       w_cntEn;
  logic [3:0] w_bitCnt;
  logic       w_cntLast;

  bit_counter u_bitCounter (
    .i_clk   (clk),
    .i_n_rst (n_rst),
    .i_clr   (w_cntClr),
    .i_en    (w_cntEn),
    .o_count (w_bitCnt)
  );

  assign w_cntLast = (w_bitCnt == 4'(BITS_PER_BYTE - 1));

  assign rx_enable     = (r_state == ADDR) || (r_state == DATA);
  assign sda_drive_low = r_sda;
  assign byte_out      = r_byteOut;
  assign byte_valid    = r_valid;
  assign addr_match    = r_match;
  assign overrun       = r_overrun;

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and control decode. START beats STOP, and both beat any SCL
  // edge in the same cycle. The ACK and NACK states share one phase tracker;
  // only the ACK states actually pull SDA low.
  always_comb begin
    w_stateNext  = r_state;
    w_phaseNext  = r_phase;
    w_sdaNext    = r_sda;
    w_matchNext  = r_match;
    w_load       = 1'b0;
    w_setOverrun = 1'b0;
    w_cntClr     = 1'b0;
    w_cntEn      = 1'b0;

    if (start_found) begin
      w_stateNext = ADDR;
      w_phaseNext = PH_WAIT_FALL;
      w_sdaNext   = 1'b0;
      w_matchNext = 1'b0;
      w_cntClr    = 1'b1;
    end else if (stop_found) begin
      w_stateNext = IDLE;
      w_phaseNext = PH_WAIT_FALL;
      w_sdaNext   = 1'b0;
      w_matchNext = 1'b0;
      w_cntClr    = 1'b1;
    end else begin
      case (r_state)
        ADDR, DATA: begin
          if (rising_edge_found) begin
            w_cntEn = 1'b1;
            if (w_cntLast) begin
              w_stateNext = (r_state == ADDR) ? ADDR_CHK : DATA_LOAD;
            end
          end
        end

        ADDR_CHK: begin
          w_phaseNext = PH_WAIT_FALL;
          if ((rx_data[7:1] == SLAVE_ADDR) && !rx_data[0]) begin
            w_stateNext = ACK_ADDR;
          end else begin
            w_stateNext = WAIT_STOP;
          end
        end

        DATA_LOAD: begin
          w_phaseNext = PH_WAIT_FALL;
          if (!r_valid || byte_ready) begin
            w_load      = 1'b1;
            w_stateNext = ACK_DATA;
          end else begin
            w_setOverrun = 1'b1;
            w_stateNext  = NACK;
          end
        end

        ACK_ADDR, ACK_DATA, NACK: begin
          case (r_phase)
            PH_WAIT_FALL: begin
              if (falling_edge_found) begin
                w_phaseNext = PH_WAIT_RISE;
                if (r_state != NACK) begin
                  w_sdaNext = 1'b1;
                end
                if (r_state == ACK_ADDR) begin
                  w_matchNext = 1'b1;
                end
              end
            end
            PH_WAIT_RISE: begin
              if (rising_edge_found) begin
                w_phaseNext = PH_WAIT_END;
              end
            end
            PH_WAIT_END: begin
              if (falling_edge_found) begin
                w_phaseNext = PH_WAIT_FALL;
                w_sdaNext   = 1'b0;
                w_stateNext = (r_state == NACK) ? WAIT_STOP : DATA;
              end
            end
            default: begin
              w_phaseNext = PH_WAIT_FALL;
            end
          endcase
        end

        IDLE, WAIT_STOP: begin
        end

        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // Bus-side registers: ACK phase, SDA drive and address-match flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_phase <= PH_WAIT_FALL;
      r_sda   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_phase <= w_phaseNext;
      r_sda   <= w_sdaNext;
      r_match <= w_matchNext;
    end
  end

  // Consumer-side handshake. A load in the same cycle as a transfer keeps
  // byte_valid high so the new byte is not lost. Setting overrun wins over
  // a simultaneous clear so a drop is never missed.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_byteOut <= 8'h00;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_byteOut <= rx_data;
        r_valid   <= 1'b1;
      end else if (r_valid && byte_ready) begin
        r_valid <= 1'b0;
      end

      if (w_setOverrun) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule
